// File: rtl/event_fifo_pkg.sv
// Shared types and defaults for the DVS event FIFO.
// Used by the FIFO itself, the event packer and the RAVENS driver.
package event_fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_FWFT     = 1;
  localparam int DEF_AE_LEVEL = 1;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/event_fifo.sv
// Event FIFO: count-tracked fullness, programmable thresholds,
// sticky error flags, high-water mark and FWFT/registered read.
module event_fifo
  import event_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int FWFT     = DEF_FWFT,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  localparam int AW      = addr_w(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    max_level,
  output logic             overflow,
  output logic             underflow
);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_max;
  logic             r_ovf;
  logic             r_unf;
  logic             w_empty;
  logic             w_full;
  logic             w_pop_acc;
  logic             w_push_acc;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_rd_data;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop_acc  = pop & ~w_empty;
  assign w_push_acc = push & (~w_full | w_pop_acc);
  assign w_cnt_nxt  = r_count
                    + {{AW{1'b0}}, w_push_acc}
                    - {{AW{1'b0}}, w_pop_acc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_max    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_cnt_nxt;
      // A new error in the clearing cycle keeps its flag set
      r_ovf <= (push & ~w_push_acc) | (r_ovf & ~err_clr);
      r_unf <= (pop & w_empty) | (r_unf & ~err_clr);
      if (err_clr)                r_max <= w_cnt_nxt;
      else if (w_cnt_nxt > r_max) r_max <= w_cnt_nxt;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_push_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = w_empty ? '0 : w_rd_data;
    end else begin : g_reg
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_dout <= '0;
        else if (w_pop_acc) r_dout <= w_rd_data;
      end
      assign data_out = r_dout;
    end
  endgenerate

  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign count        = r_count;
  assign max_level    = r_max;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_event_fifo.sv
// Directed bench for event_fifo: one FWFT and one registered-read
// instance share the same stimulus (WIDTH=8, DEPTH=4, AF=3, AE=1).
module tb_event_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] dout1, dout0;
  logic       emp1, ful1, ae1, af1, ovf1, unf1;
  logic       emp0, ful0, ae0, af0, ovf0, unf0;
  logic [2:0] cnt1, max1, cnt0, max0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  event_fifo #(
    .WIDTH(8), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)
  ) u_dut (
    .clk(clk), .rst(rst), .data_in(din), .push(push), .pop(pop),
    .err_clr(clr), .data_out(dout1), .empty(emp1), .full(ful1),
    .almost_empty(ae1), .almost_full(af1), .count(cnt1),
    .max_level(max1), .overflow(ovf1), .underflow(unf1)
  );

  event_fifo #(
    .WIDTH(8), .DEPTH(4), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .data_in(din), .push(push), .pop(pop),
    .err_clr(clr), .data_out(dout0), .empty(emp0), .full(ful0),
    .almost_empty(ae0), .almost_full(af0), .count(cnt0),
    .max_level(max0), .overflow(ovf0), .underflow(unf0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] d);
    din  = d;
    push = 1'b1;
    step();
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_cnt"}, 32'(cnt1), 0);
    chk({tag, "_emp"}, 32'(emp1), 1);
    chk({tag, "_ful"}, 32'(ful1), 0);
    chk({tag, "_ae"},  32'(ae1), 1);
    chk({tag, "_af"},  32'(af1), 0);
    chk({tag, "_ovf"}, 32'(ovf1), 0);
    chk({tag, "_unf"}, 32'(unf1), 0);
    chk({tag, "_max"}, 32'(max1), 0);
    chk({tag, "_do1"}, 32'(dout1), 0);
    chk({tag, "_do0"}, 32'(dout0), 0);
    chk({tag, "_cnt0"}, 32'(cnt0), 0);
  endtask

  initial begin
    #2;
    rst_vals("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_push(8'h11);
    chk("f1_cnt", 32'(cnt1), 1);
    chk("f1_do",  32'(dout1), 32'h11);
    chk("f1_emp", 32'(emp1), 0);
    chk("f1_ae",  32'(ae1), 1);
    do_push(8'h22);
    chk("f2_ae", 32'(ae1), 0);
    chk("f2_af", 32'(af1), 0);
    do_push(8'h33);
    chk("f3_af",  32'(af1), 1);
    chk("f3_ful", 32'(ful1), 0);
    do_push(8'h44);
    chk("f4_ful", 32'(ful1), 1);
    chk("f4_cnt", 32'(cnt1), 4);
    chk("f4_ful0", 32'(ful0), 1);

    do_push(8'h55);
    chk("ov_flag", 32'(ovf1), 1);
    chk("ov_cnt",  32'(cnt1), 4);
    chk("ov_max",  32'(max1), 4);
    clr = 1'b1;
    step();
    chk("ovc_flag", 32'(ovf1), 0);
    chk("ovc_max",  32'(max1), 4);

    chk("sim_head", 32'(dout1), 32'h11);
    din = 8'h66; push = 1'b1; pop = 1'b1;
    step();
    chk("sim_cnt", 32'(cnt1), 4);
    chk("sim_do1", 32'(dout1), 32'h22);
    chk("sim_do0", 32'(dout0), 32'h11);
    chk("sim_ovf", 32'(ovf1), 0);

    begin
      logic [7:0] exp_q [4];
      exp_q[0] = 8'h22; exp_q[1] = 8'h33;
      exp_q[2] = 8'h44; exp_q[3] = 8'h66;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("dr%0d_do1", i), 32'(dout1), 32'(exp_q[i]));
        pop = 1'b1;
        step();
        chk($sformatf("dr%0d_do0", i), 32'(dout0), 32'(exp_q[i]));
        chk($sformatf("dr%0d_cnt", i), 32'(cnt1), 32'(3 - i));
      end
    end
    chk("dr_emp", 32'(emp1), 1);
    chk("dr_do1", 32'(dout1), 0);

    pop = 1'b1;
    step();
    chk("un_flag", 32'(unf1), 1);
    chk("un_do1",  32'(dout1), 0);
    chk("un_do0",  32'(dout0), 32'h66);
    clr = 1'b1;
    step();
    chk("unc_flag", 32'(unf1), 0);
    chk("unc_max",  32'(max1), 0);

    din = 8'h77; push = 1'b1; pop = 1'b1;
    step();
    chk("pp_cnt", 32'(cnt1), 1);
    chk("pp_unf", 32'(unf1), 1);
    chk("pp_do1", 32'(dout1), 32'h77);
    chk("pp_max", 32'(max1), 1);

    pop = 1'b1;
    step();
    chk("rr_do0", 32'(dout0), 32'h77);
    chk("rr_cnt", 32'(cnt0), 0);
    step();
    chk("rr_hold", 32'(dout0), 32'h77);

    clr = 1'b1;
    step();
    chk("ew_pre", 32'(unf1), 0);
    pop = 1'b1; clr = 1'b1;
    step();
    chk("ew_unf", 32'(unf1), 1);
    clr = 1'b1;
    step();
    chk("ew_clr", 32'(unf1), 0);

    do_push(8'hA1);
    do_push(8'hA2);
    do_push(8'hA3);
    chk("ms_cnt", 32'(cnt1), 3);
    chk("ms_max", 32'(max1), 3);
    #2 rst = 1'b1;
    #1;
    rst_vals("mrst");
    step();
    rst = 1'b0;
    do_push(8'h7E);
    chk("ar_do1", 32'(dout1), 32'h7E);
    chk("ar_cnt", 32'(cnt1), 1);
    pop = 1'b1;
    step();
    chk("ar_do0", 32'(dout0), 32'h7E);
    chk("ar_emp", 32'(emp1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
